// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// ------------
// Parametrised UART receiver with an integrated first-word-fall-through
// receive FIFO. The serial line is double-flopped, then a single down-counting
// baud timer samples each bit at its midpoint. A completed frame is pushed into
// the FIFO, or reported as a framing error, parity error or overrun.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   rxd        asynchronous serial input, idle high
//   rd_en      pop the head entry (ignored while empty)
//   rd_data    head of the FIFO, valid while empty is low (zero when empty)
//   empty      FIFO holds no entries
//   full       FIFO holds FIFO_DEPTH entries
//   count      current occupancy
//   frame_err  one-cycle pulse: a stop bit was sampled low
//   parity_err one-cycle pulse: parity mismatch on an otherwise good frame
//   overrun    one-cycle pulse: good frame arrived while full with no pop
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              rxd,
  input  logic                              rd_en,
  output logic [DATA_BITS-1:0]              rd_data,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              frame_err,
  output logic                              parity_err,
  output logic                              overrun
);

  localparam int CPB    = CLK_FREQ / BAUD;
  localparam int CNT_W  = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BITS - 1);
  localparam logic [OCC_W-1:0] DEPTH_OCC   = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY_BIT,
    STOP
  } state_t;

  // Line synchroniser
  logic rxMeta_q;
  logic rxs_q;

  // Receiver state
  state_t               state_q,   state_d;
  logic [CNT_W-1:0]     bitCnt_q,  bitCnt_d;
  logic [IDX_W-1:0]     bitIdx_q,  bitIdx_d;
  logic [DATA_BITS-1:0] shreg_q,   shreg_d;
  logic                 parBad_q,  parBad_d;
  logic                 stopBad_q, stopBad_d;
  logic                 stopIdx_q, stopIdx_d;

  // Completion strobes from the receiver, valid in the final stop-sample cycle
  logic frameDone;
  logic frameBad;
  logic expParity;
  logic tick;

  // FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wrPtr_q;
  logic [PTR_W-1:0]     rdPtr_q;
  logic [OCC_W-1:0]     count_q;
  logic                 fifoEmpty;
  logic                 fifoFull;
  logic                 pushReq;
  logic                 push;
  logic                 pop;
  logic                 overrunEvt;

  // Error pulse registers
  logic frameErr_q;
  logic parityErr_q;
  logic overrun_q;

  // Two-flop synchroniser for the asynchronous line. Both flops reset to the
  // idle level so that a reset can never look like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxMeta_q <= 1'b1;
      rxs_q    <= 1'b1;
    end else begin
      rxMeta_q <= rxd;
      rxs_q    <= rxMeta_q;
    end
  end

  // Receiver state register. A reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      bitIdx_q  <= '0;
      shreg_q   <= '0;
      parBad_q  <= 1'b0;
      stopBad_q <= 1'b0;
      stopIdx_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      bitIdx_q  <= bitIdx_d;
      shreg_q   <= shreg_d;
      parBad_q  <= parBad_d;
      stopBad_q <= stopBad_d;
      stopIdx_q <= stopIdx_d;
    end
  end

  // Odd parity expects the inverted XOR of the data bits, even the plain XOR.
  assign expParity = (PARITY == 1) ? ~(^shreg_q) : (^shreg_q);

  // The baud counter reaching zero marks the midpoint of the current bit.
  assign tick = (bitCnt_q == '0);

  // Receiver next-state logic. The first counter load is half a bit so that
  // every later reload of a full bit lands on a bit centre. The final stop
  // sample returns to IDLE in the same cycle so a back-to-back start edge is
  // seen on the very next cycle.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    bitIdx_d  = bitIdx_q;
    shreg_d   = shreg_q;
    parBad_d  = parBad_q;
    stopBad_d = stopBad_q;
    stopIdx_d = stopIdx_q;
    frameDone = 1'b0;
    frameBad  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d  = START;
          bitCnt_d = HALF_RELOAD;
        end
      end

      START: begin
        if (!tick) begin
          bitCnt_d = bitCnt_q - 1'b1;
        end else if (rxs_q) begin
          // Line already back high at mid start bit: a glitch, not a frame.
          state_d = IDLE;
        end else begin
          state_d   = DATA;
          bitCnt_d  = FULL_RELOAD;
          bitIdx_d  = '0;
          parBad_d  = 1'b0;
          stopBad_d = 1'b0;
          stopIdx_d = 1'b0;
        end
      end

      DATA: begin
        if (!tick) begin
          bitCnt_d = bitCnt_q - 1'b1;
        end else begin
          shreg_d[bitIdx_q] = rxs_q;
          bitCnt_d          = FULL_RELOAD;
          if (bitIdx_q == LAST_IDX) begin
            state_d = (PARITY != 0) ? PARITY_BIT : STOP;
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end
      end

      PARITY_BIT: begin
        if (!tick) begin
          bitCnt_d = bitCnt_q - 1'b1;
        end else begin
          parBad_d = (rxs_q != expParity);
          bitCnt_d = FULL_RELOAD;
          state_d  = STOP;
        end
      end

      STOP: begin
        if (!tick) begin
          bitCnt_d = bitCnt_q - 1'b1;
        end else if ((STOP_BITS == 2) && !stopIdx_q) begin
          stopIdx_d = 1'b1;
          stopBad_d = stopBad_q | ~rxs_q;
          bitCnt_d  = FULL_RELOAD;
        end else begin
          state_d   = IDLE;
          frameDone = 1'b1;
          frameBad  = stopBad_q | ~rxs_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Completion handling. Framing beats parity, parity beats the push. A push
  // into a full FIFO is still accepted if the reader pops in the same cycle.
  assign fifoEmpty  = (count_q == '0);
  assign fifoFull   = (count_q == DEPTH_OCC);
  assign pop        = rd_en & ~fifoEmpty;
  assign pushReq    = frameDone & ~frameBad & ~parBad_q;
  assign push       = pushReq & (~fifoFull | rd_en);
  assign overrunEvt = pushReq & fifoFull & ~rd_en;

  // Error pulses appear the cycle after the final stop sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      frameErr_q  <= 1'b0;
      parityErr_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frameErr_q  <= frameDone & frameBad;
      parityErr_q <= frameDone & ~frameBad & parBad_q;
      overrun_q   <= overrunEvt;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally at FIFO_DEPTH since
  // the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array has no reset; stale entries are never visible because the
  // read port is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= shreg_q;
    end
  end

  assign rd_data    = fifoEmpty ? '0 : mem_q[rdPtr_q];
  assign empty      = fifoEmpty;
  assign full       = fifoFull;
  assign count      = count_q;
  assign frame_err  = frameErr_q;
  assign parity_err = parityErr_q;
  assign overrun    = overrun_q;

endmodule
